// File: rtl/ltssm_main_sequencer_if.sv
// Bundle between the LTSSM main sequencer and the Rx/Tx sub-LTSSMs.
// master: sequencer side (drives substate/link status); slave: sub-LTSSM side.
interface ltssm_main_sequencer_if;
    logic       rxFinish;
    logic       txFinish;
    logic [3:0] rxExitTo;
    logic [4:0] numberOfDetectedLanes;
    logic       directedDetect;
    logic [3:0] substate;
    logic [7:0] linkNumber;
    logic       linkUp;
    logic       stateChange;
    logic       timeoutEvent;

    modport master (
        input  rxFinish,
        input  txFinish,
        input  rxExitTo,
        input  numberOfDetectedLanes,
        input  directedDetect,
        output substate,
        output linkNumber,
        output linkUp,
        output stateChange,
        output timeoutEvent
    );

    modport slave (
        output rxFinish,
        output txFinish,
        output rxExitTo,
        output numberOfDetectedLanes,
        output directedDetect,
        input  substate,
        input  linkNumber,
        input  linkUp,
        input  stateChange,
        input  timeoutEvent
    );
endinterface

// File: rtl/ltssm_main_sequencer.sv
// Top-level PCIe LTSSM sequencer: drives substate, applies per-state timeouts.
// Ports: clk, reset (async active-low), bus (master modport of the sub-LTSSM bundle).
module ltssm_main_sequencer #(
    parameter logic [7:0]         LINK_NUMBER    = 8'hBB,
    parameter int                 TIMER_W        = 24,
    parameter logic [TIMER_W-1:0] QUIET_TIMEOUT  = TIMER_W'(12),
    parameter logic [TIMER_W-1:0] POLL_TIMEOUT   = TIMER_W'(24),
    parameter logic [TIMER_W-1:0] CONFIG_TIMEOUT = TIMER_W'(32)
) (
    input  logic                   clk,
    input  logic                   reset,
    ltssm_main_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_DET_QUIET   = 4'd0,
        S_DET_ACTIVE  = 4'd1,
        S_POLL_ACTIVE = 4'd2,
        S_POLL_CFG    = 4'd3,
        S_CFG_LWSTART = 4'd4,
        S_CFG_LWACC   = 4'd5,
        S_CFG_LNWAIT  = 4'd6,
        S_CFG_LNACC   = 4'd7,
        S_CFG_CMPL    = 4'd8,
        S_CFG_IDLE    = 4'd9,
        S_L0          = 4'd10
    } state_e;

    localparam logic [7:0] PAD = 8'hF7;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 link_up_q, link_up_d;
    logic                 state_change_q, state_change_d;
    logic                 timeout_event_q, timeout_event_d;
    logic [7:0]           link_number_q, link_number_d;

    logic                 rx_ok;
    logic                 tx_ok;
    logic                 both_ok;
    logic                 exit_det;
    logic [TIMER_W-1:0]   limit;
    logic                 timed_out;
    logic                 enter;

    always_comb begin
        // Finish flags seen in the entry cycle may be stale from the
        // previous substate, so they are masked for that one cycle.
        rx_ok    = bus.rxFinish & ~state_change_q;
        tx_ok    = bus.txFinish & ~state_change_q;
        both_ok  = rx_ok & tx_ok;
        exit_det = rx_ok & (bus.rxExitTo == 4'd0);

        unique case (state_q)
            S_DET_QUIET:               limit = QUIET_TIMEOUT;
            S_POLL_ACTIVE, S_POLL_CFG: limit = POLL_TIMEOUT;
            S_CFG_LWSTART, S_CFG_LWACC,
            S_CFG_LNWAIT, S_CFG_LNACC,
            S_CFG_CMPL, S_CFG_IDLE:    limit = CONFIG_TIMEOUT;
            default:                   limit = '0;
        endcase
        timed_out = (limit != '0) && (timer_q == limit - TIMER_W'(1));

        state_d         = state_q;
        enter           = 1'b0;
        timeout_event_d = 1'b0;

        unique case (state_q)
            S_DET_QUIET: begin
                // Timeout is the normal exit here, so no timeoutEvent.
                if (rx_ok || timed_out) begin
                    state_d = S_DET_ACTIVE;
                    enter   = 1'b1;
                end else if (bus.directedDetect) begin
                    enter   = 1'b1;
                end
            end
            S_DET_ACTIVE: begin
                if (bus.directedDetect) begin
                    state_d = S_DET_QUIET;
                    enter   = 1'b1;
                end else if (tx_ok) begin
                    state_d = (bus.numberOfDetectedLanes != 5'd0)
                            ? S_POLL_ACTIVE : S_DET_QUIET;
                    enter   = 1'b1;
                end
            end
            S_POLL_ACTIVE, S_POLL_CFG, S_CFG_LWSTART, S_CFG_LWACC,
            S_CFG_LNWAIT, S_CFG_LNACC, S_CFG_CMPL: begin
                if (bus.directedDetect || exit_det) begin
                    state_d = S_DET_QUIET;
                    enter   = 1'b1;
                end else if (both_ok) begin
                    state_d = state_e'(state_q + 4'd1);
                    enter   = 1'b1;
                end else if (timed_out) begin
                    state_d         = S_DET_QUIET;
                    enter           = 1'b1;
                    timeout_event_d = 1'b1;
                end
            end
            S_CFG_IDLE: begin
                if (bus.directedDetect) begin
                    state_d = S_DET_QUIET;
                    enter   = 1'b1;
                end else if (both_ok) begin
                    state_d = S_L0;
                    enter   = 1'b1;
                end else if (timed_out) begin
                    state_d         = S_DET_QUIET;
                    enter           = 1'b1;
                    timeout_event_d = 1'b1;
                end
            end
            S_L0: begin
                if (bus.directedDetect || exit_det) begin
                    state_d = S_DET_QUIET;
                    enter   = 1'b1;
                end
            end
            default: begin
                state_d = S_DET_QUIET;
                enter   = 1'b1;
            end
        endcase

        // L0 has no timeout, so its timer is simply held.
        if (enter) begin
            timer_d = '0;
        end else if (state_q == S_L0 || timer_q == '1) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + TIMER_W'(1);
        end

        state_change_d = enter;
        link_up_d      = (state_d == S_L0);
        link_number_d  = (state_d >= S_CFG_LWSTART) ? LINK_NUMBER : PAD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_DET_QUIET;
            timer_q         <= '0;
            link_up_q       <= 1'b0;
            state_change_q  <= 1'b1;
            timeout_event_q <= 1'b0;
            link_number_q   <= PAD;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            link_up_q       <= link_up_d;
            state_change_q  <= state_change_d;
            timeout_event_q <= timeout_event_d;
            link_number_q   <= link_number_d;
        end
    end

    assign bus.substate     = state_q;
    assign bus.linkNumber   = link_number_q;
    assign bus.linkUp       = link_up_q;
    assign bus.stateChange  = state_change_q;
    assign bus.timeoutEvent = timeout_event_q;

endmodule
